// File: rtl/stepper_step_conditioner_pkg.sv
// rtl/stepper_step_conditioner_pkg.sv - shared constants for the step conditioner
//
// Package stepper_pkg: state encoding, datapath widths, default pulse timing
// and the position increment helper.
package stepper_pkg;

  localparam int POS_W = 16;
  localparam int CNT_W = 16;

  // Kept as plain 2-bit constants so legacy tooling can match the encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  localparam logic [CNT_W-1:0] DEF_PULSE_HIGH = 16'd5;
  localparam logic [CNT_W-1:0] DEF_PULSE_LOW  = 16'd5;
  localparam logic [CNT_W-1:0] DEF_DIR_SETUP  = 16'd10;

  // +1 forward, -1 reverse; the add wraps modulo 2^POS_W.
  function automatic logic [POS_W-1:0] step_delta(input logic dir);
    return dir ? POS_W'(1) : {POS_W{1'b1}};
  endfunction

endpackage

// File: rtl/stepper_step_conditioner_if.sv
// rtl/stepper_step_conditioner_if.sv - controller-side and driver-side signal bundle
//
// master: the upstream controller (drives step_in, dir_in, clear_fault)
// slave : the conditioner (drives drv_step, drv_dir, position, busy, overrun)
interface stepper_step_conditioner_if;
  import stepper_pkg::*;

  logic             step_in;
  logic             dir_in;
  logic             clear_fault;
  logic             drv_step;
  logic             drv_dir;
  logic [POS_W-1:0] position;
  logic             busy;
  logic             overrun;

  modport master (
    output step_in, dir_in, clear_fault,
    input  drv_step, drv_dir, position, busy, overrun
  );

  modport slave (
    input  step_in, dir_in, clear_fault,
    output drv_step, drv_dir, position, busy, overrun
  );

endinterface

// File: rtl/stepper_step_conditioner_home_sync.sv
// rtl/stepper_step_conditioner_home_sync.sv - home switch synchronizer and falling-edge detect
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   home_n      : raw active-low home switch (asynchronous to clk)
//   home_fall   : one-cycle strobe on a falling edge of the synchronized switch
module stepper_home_sync (
  input  logic clk,
  input  logic reset,
  input  logic home_n,
  output logic home_fall
);

  logic sync_1;
  logic sync_2;
  logic sync_2_d;

  // Reset to the released (high) level so leaving reset never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1   <= 1'b1;
      sync_2   <= 1'b1;
      sync_2_d <= 1'b1;
    end else begin
      sync_1   <= home_n;
      sync_2   <= sync_1;
      sync_2_d <= sync_2;
    end
  end

  assign home_fall = sync_2_d & ~sync_2;

endmodule

// File: rtl/stepper_step_conditioner.sv
// rtl/stepper_step_conditioner.sv - stretches controller step pulses for the driver chip
//
// Conditions 1-cycle step requests into PULSE_HIGH/PULSE_LOW wide pulses,
// holds DIR_SETUP cycles of direction setup before a step, buffers one
// early step and tracks a signed 16-bit position.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   home_n     : active-low home switch, zeroes position (STEPPER_HOME_ZERO_EN only)
//   io (slave) : step_in, dir_in, clear_fault in;
//                drv_step, drv_dir, position, busy, overrun out (all registered)
//
// Build option: define STEPPER_HOME_ZERO_EN to add the home_n input.
module stepper_step_conditioner
  import stepper_pkg::*;
#(
  parameter logic [CNT_W-1:0] PULSE_HIGH = DEF_PULSE_HIGH,
  parameter logic [CNT_W-1:0] PULSE_LOW  = DEF_PULSE_LOW,
  parameter logic [CNT_W-1:0] DIR_SETUP  = DEF_DIR_SETUP
) (
  input  logic clk,
  input  logic reset,
`ifdef STEPPER_HOME_ZERO_EN
  input  logic home_n,
`endif
  stepper_step_conditioner_if.slave io
);

  localparam logic [CNT_W-1:0] HIGH_LAST  = PULSE_HIGH - 1'b1;
  localparam logic [CNT_W-1:0] LOW_LAST   = PULSE_LOW - 1'b1;
  localparam logic [CNT_W-1:0] SETUP_LAST = DIR_SETUP - 1'b1;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pending, pending_n;
  logic             drv_step_n;
  logic             drv_dir_n;
  logic             overrun_n;
  logic             busy_n;
  logic [POS_W-1:0] pos_n;
  logic             issue;
  logic             home_zero;

`ifdef STEPPER_HOME_ZERO_EN
  stepper_home_sync u_home_sync (
    .clk       (clk),
    .reset     (reset),
    .home_n    (home_n),
    .home_fall (home_zero)
  );
`else
  assign home_zero = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pending_n  = pending;
    drv_step_n = io.drv_step;
    drv_dir_n  = io.drv_dir;
    overrun_n  = io.overrun;
    pos_n      = io.position;
    issue      = 1'b0;

    case (state)
      ST_IDLE: begin
        // A direction change always takes priority; the step waits in pending.
        if (io.dir_in != io.drv_dir) begin
          drv_dir_n = io.dir_in;
          cnt_n     = '0;
          state_n   = ST_SETUP;
        end else if (io.step_in || pending) begin
          issue = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt == HIGH_LAST) begin
          drv_step_n = 1'b0;
          cnt_n      = '0;
          state_n    = ST_LOW;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_LOW: begin
        if (cnt == LOW_LAST) begin
          cnt_n = '0;
          // Back-to-back only when no new setup time is needed.
          if (pending && (io.dir_in == io.drv_dir)) begin
            issue = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    if (issue) begin
      drv_step_n = 1'b1;
      cnt_n      = '0;
      state_n    = ST_HIGH;
      pending_n  = 1'b0;
      pos_n      = io.position + step_delta(io.drv_dir);
    end

    // Clear first so a simultaneous overrun event wins.
    if (io.clear_fault) begin
      overrun_n = 1'b0;
    end

    // issue without a prior pending can only be a direct step from IDLE,
    // which consumes step_in itself; anything else lands in the one-deep buffer.
    if (io.step_in) begin
      if (pending) begin
        overrun_n = 1'b1;
      end else if (!issue) begin
        pending_n = 1'b1;
      end
    end

    // Homing overrides a coincident step: the pulse goes out uncounted.
    if (home_zero) begin
      pos_n = '0;
    end

    busy_n = (state_n != ST_IDLE) || pending_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pending     <= 1'b0;
      io.drv_step <= 1'b0;
      io.drv_dir  <= 1'b0;
      io.position <= '0;
      io.overrun  <= 1'b0;
      io.busy     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pending     <= pending_n;
      io.drv_step <= drv_step_n;
      io.drv_dir  <= drv_dir_n;
      io.position <= pos_n;
      io.overrun  <= overrun_n;
      io.busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_stepper_step_conditioner.sv
// tb/tb_stepper_step_conditioner.sv - self-checking bench for stepper_step_conditioner
module tb_stepper_step_conditioner;
  import stepper_pkg::*;

  localparam int H  = 5;
  localparam int L  = 5;
  localparam int DS = 10;
  localparam int WRAP_N = 32767;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  always #5 clk = ~clk;

  stepper_step_conditioner_if io();
  stepper_step_conditioner_if io2();

`ifdef STEPPER_HOME_ZERO_EN
  logic home_n;
  logic home_n2;
`endif

  stepper_step_conditioner dut (
    .clk   (clk),
    .reset (reset),
`ifdef STEPPER_HOME_ZERO_EN
    .home_n(home_n),
`endif
    .io    (io)
  );

  // Fast-timing instance used only to reach the position wrap point quickly.
  stepper_step_conditioner #(
    .PULSE_HIGH(16'd1),
    .PULSE_LOW (16'd1),
    .DIR_SETUP (16'd1)
  ) dut2 (
    .clk   (clk),
    .reset (reset2),
`ifdef STEPPER_HOME_ZERO_EN
    .home_n(home_n2),
`endif
    .io    (io2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic done2 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model (time-window formulation) ----------------
  // m_rise: cycle the last pulse rose; the pulse occupies [m_rise, m_rise+H+L).
  // m_setup_end: first cycle after a direction-setup window.
  int          t;
  int          m_rise;
  int          m_setup_end;
  logic        m_dir;
  logic        m_pend;
  logic        m_ovr;
  logic [15:0] m_pos;
  logic [2:0]  m_h;
  logic        s_in, d_in, cf_in, idle_prev, low_end, m_issue, m_direct, m_home;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t = 0; m_rise = -1000; m_setup_end = -1000;
      m_dir = 1'b0; m_pend = 1'b0; m_ovr = 1'b0; m_pos = 16'd0; m_h = 3'b111;
    end else begin
      t = t + 1;
      s_in = io.step_in; d_in = io.dir_in; cf_in = io.clear_fault;
      idle_prev = (t - 1 >= m_rise + H + L) && (t - 1 >= m_setup_end);
      low_end   = (t == m_rise + H + L);
      m_issue = 1'b0; m_direct = 1'b0;
      if (idle_prev) begin
        if (d_in != m_dir) begin
          m_dir = d_in;
          m_setup_end = t + DS;
        end else if (s_in || m_pend) begin
          m_issue = 1'b1;
          m_direct = !m_pend;
        end
      end else if (low_end && m_pend && (d_in == m_dir)) begin
        m_issue = 1'b1;
      end
      m_home = 1'b0;
`ifdef STEPPER_HOME_ZERO_EN
      m_home = m_h[2] && !m_h[1];
      m_h = {m_h[1], m_h[0], home_n};
`endif
      if (m_issue) begin
        m_rise = t;
        m_pos = m_pos + (m_dir ? 16'd1 : 16'hFFFF);
      end
      if (m_home) m_pos = 16'd0;
      if (cf_in) m_ovr = 1'b0;
      if (s_in && m_pend) m_ovr = 1'b1;
      m_pend = (m_pend && !m_issue) || (s_in && !m_pend && !m_direct);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model drv_step", io.drv_step, (t >= m_rise && t < m_rise + H));
      chk("model drv_dir", io.drv_dir, m_dir);
      chk("model position", io.position, m_pos);
      chk("model overrun", io.overrun, m_ovr);
      chk("model busy", io.busy,
          !((t >= m_rise + H + L) && (t >= m_setup_end)) || m_pend);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- wrap test on the fast instance ----------------
  initial begin
    reset2 = 1'b1;
    io2.step_in = 1'b0; io2.dir_in = 1'b1; io2.clear_fault = 1'b0;
`ifdef STEPPER_HOME_ZERO_EN
    home_n2 = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #2 reset2 = 1'b0;
    repeat (4) tick();
    // Step requests land in each HIGH cycle so the buffered step chains straight on.
    io2.step_in = 1'b1;
    tick();
    for (int j = 0; j < WRAP_N - 1; j++) begin
      io2.step_in = 1'b1;
      tick();
      io2.step_in = 1'b0;
      tick();
    end
    io2.step_in = 1'b0;
    repeat (10) tick();
    chk("wrap preload position", io2.position, 16'h7FFF);
    chk("wrap preload overrun", io2.overrun, 1'b0);
    io2.step_in = 1'b1;
    tick();
    io2.step_in = 1'b0;
    repeat (5) tick();
    chk("wrap 32767+1", io2.position, 16'h8000);
    io2.dir_in = 1'b0;
    io2.step_in = 1'b1;
    tick();
    io2.step_in = 1'b0;
    repeat (8) tick();
    chk("wrap -32768-1", io2.position, 16'h7FFF);
    chk("wrap drv_dir", io2.drv_dir, 1'b0);
    chk("wrap drv_step idle", io2.drv_step, 1'b0);
    chk("wrap busy idle", io2.busy, 1'b0);
    done2 = 1'b1;
  end

  // ---------------- directed + random sequence on the default instance ----------------
  int   rises;
  logic prev_step;

  initial begin
    reset = 1'b1;
    io.step_in = 1'b0; io.dir_in = 1'b0; io.clear_fault = 1'b0;
`ifdef STEPPER_HOME_ZERO_EN
    home_n = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    chk("reset drv_step", io.drv_step, 1'b0);
    chk("reset drv_dir", io.drv_dir, 1'b0);
    chk("reset position", io.position, 16'd0);
    chk("reset overrun", io.overrun, 1'b0);
    chk("reset busy", io.busy, 1'b0);
    repeat (5) tick();

    // Single step, direction already matching.
    io.step_in = 1'b1;
    tick();
    io.step_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("single step high", io.drv_step, 1'b1);
      if (i == 0) chk("single step position", io.position, 16'hFFFF);
      tick();
    end
    chk("single step low", io.drv_step, 1'b0);
    chk("single busy in low", io.busy, 1'b1);
    repeat (4) tick();
    chk("single busy last low", io.busy, 1'b1);
    tick();
    chk("single busy idle", io.busy, 1'b0);

    // Direction change with a step in the same cycle.
    do_reset();
    repeat (4) tick();
    io.dir_in = 1'b1;
    io.step_in = 1'b1;
    tick();
    io.step_in = 1'b0;
    chk("dir change drv_dir", io.drv_dir, 1'b1);
    chk("dir change no step yet", io.drv_step, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("dir setup hold", io.drv_step, 1'b0);
    end
    tick();
    chk("dir setup rise", io.drv_step, 1'b1);
    chk("dir setup position", io.position, 16'd1);
    repeat (12) tick();

    // Two steps three cycles apart: second is buffered.
    io.dir_in = 1'b0;
    do_reset();
    repeat (4) tick();
    io.step_in = 1'b1;
    tick();
    io.step_in = 1'b0;
    tick();
    tick();
    io.step_in = 1'b1;
    tick();
    io.step_in = 1'b0;
    repeat (6) tick();
    chk("buffered gap low", io.drv_step, 1'b0);
    tick();
    chk("buffered second rise", io.drv_step, 1'b1);
    chk("buffered position", io.position, 16'hFFFE);
    chk("buffered overrun", io.overrun, 1'b0);
    repeat (5) tick();
    chk("buffered second fall", io.drv_step, 1'b0);
    repeat (12) tick();

    // Three steps within four cycles: third dropped.
    do_reset();
    repeat (4) tick();
    rises = 0;
    prev_step = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (io.drv_step && !prev_step) rises++;
      prev_step = io.drv_step;
      if (i == 4) chk("overrun before drop", io.overrun, 1'b0);
      if (i == 5) chk("overrun on drop", io.overrun, 1'b1);
      io.step_in = (i == 0 || i == 2 || i == 4);
      tick();
    end
    io.step_in = 1'b0;
    chk("drop pulse count", rises, 2);
    chk("drop position", io.position, 16'hFFFE);
    chk("overrun sticky", io.overrun, 1'b1);
    io.clear_fault = 1'b1;
    tick();
    io.clear_fault = 1'b0;
    chk("clear_fault", io.overrun, 1'b0);

    // Overrun set and clear in the same cycle: set wins.
    io.step_in = 1'b1;
    tick();
    tick();
    io.clear_fault = 1'b1;
    tick();
    io.step_in = 1'b0;
    io.clear_fault = 1'b0;
    chk("set beats clear", io.overrun, 1'b1);
    io.clear_fault = 1'b1;
    tick();
    io.clear_fault = 1'b0;
    repeat (25) tick();
    chk("cleared after burst", io.overrun, 1'b0);

    // Reset asserted in the middle of a HIGH phase.
    do_reset();
    repeat (4) tick();
    io.step_in = 1'b1;
    tick();
    io.step_in = 1'b1;
    tick();
    io.step_in = 1'b0;
    chk("pre-reset high", io.drv_step, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("async reset drv_step", io.drv_step, 1'b0);
    chk("async reset position", io.position, 16'd0);
    chk("async reset busy", io.busy, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("no residual pulse", io.drv_step, 1'b0);
    end

`ifdef STEPPER_HOME_ZERO_EN
    // Homing: build position 7, then pull home_n low.
    do_reset();
    io.dir_in = 1'b1;
    repeat (7) begin
      io.step_in = 1'b1;
      tick();
      io.step_in = 1'b0;
      repeat (25) tick();
    end
    chk("home preload", io.position, 16'd7);
    home_n = 1'b0;
    tick();
    chk("home edge1", io.position, 16'd7);
    tick();
    chk("home edge2", io.position, 16'd7);
    tick();
    chk("home edge3 zero", io.position, 16'd0);
    home_n = 1'b1;
    repeat (5) tick();
    io.step_in = 1'b1;
    tick();
    io.step_in = 1'b0;
    repeat (25) tick();
    chk("home restep", io.position, 16'd1);
    // Home event on the same edge as a step rise.
    home_n = 1'b0;
    tick();
    tick();
    io.step_in = 1'b1;
    tick();
    io.step_in = 1'b0;
    chk("home coincide step", io.drv_step, 1'b1);
    chk("home coincide zero", io.position, 16'd0);
    home_n = 1'b1;
    repeat (25) tick();
    chk("home coincide hold", io.position, 16'd0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      io.step_in = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 59) == 0) io.dir_in = ~io.dir_in;
      io.clear_fault = ($urandom_range(0, 39) == 0);
`ifdef STEPPER_HOME_ZERO_EN
      if ($urandom_range(0, 199) == 0) home_n = ~home_n;
`endif
      tick();
    end
    io.step_in = 1'b0;
    io.clear_fault = 1'b0;
    repeat (30) tick();

    for (int i = 0; i < 90000 && !done2; i++) @(posedge clk);
    chk("wrap thread finished", done2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
